// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and the step-counter width helper.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // Bits needed to hold the step count WIDTH/UNROLL (inclusive).
    function automatic int md_cnt_width(input int width, input int unroll);
        return $clog2(width / unroll + 1);
    endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration on a {hi, lo} working pair.
//   mode_i = 0: shift-add multiply step. lo holds the remaining multiplier
//               bits (LSB first) and receives product bits from the top.
//   mode_i = 1: restoring divide step. lo holds the remaining dividend bits
//               (MSB first) and receives quotient bits at the bottom; hi is
//               the partial remainder, always < m_i between steps.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;

    // Compute both step flavours and select by mode.
    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        sh   = {hi_i, lo_i[WIDTH-1]};
        // Since hi_i < m_i, sh < 2*m_i: a non-negative difference always
        // fits in WIDTH bits, so bit WIDTH is exactly the borrow.
        diff = sh - {1'b0, m_i};
        hi_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
        if (mode_i) begin
            if (diff[WIDTH]) begin
                hi_o = sh[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end else begin
                hi_o = diff[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, iterated UNROLL steps per
// clock for WIDTH/UNROLL clocks, then sign-corrected in FIX and written to
// HI/LO. Handshake: an operation is accepted on a rising edge where the unit
// is IDLE, start=1 and abort=0; busy is then high for N+1 cycles, done pulses
// during the final (FIX) cycle and HI/LO hold the result from the next cycle.
module md_iter_unit
    import md_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = md_cnt_width(WIDTH, UNROLL);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             write_res;
    logic             in_neg_a, in_neg_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] run_hi, run_lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [2*WIDTH-1:0] prod_fix;

    // UNROLL chained radix-2 steps; stage 0 reads the working registers.
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        logic [WIDTH-1:0] hi_in, lo_in, hi_out, lo_out;
        if (g == 0) begin : g_first
            assign hi_in = acc_q;
            assign lo_in = mq_q;
        end else begin : g_next
            assign hi_in = g_step[g-1].hi_out;
            assign lo_in = g_step[g-1].lo_out;
        end
        md_step #(.WIDTH(WIDTH)) u_step (
            .mode_i (op_q[1]),
            .hi_i   (hi_in),
            .lo_i   (lo_in),
            .m_i    (m_q),
            .hi_o   (hi_out),
            .lo_o   (lo_out)
        );
    end
    assign run_hi = g_step[UNROLL-1].hi_out;
    assign run_lo = g_step[UNROLL-1].lo_out;

    // Operand signs and magnitudes; only signed ops (op[0]==0) see a sign.
    always_comb begin
        in_neg_a = ~op[0] & a[WIDTH-1];
        in_neg_b = ~op[0] & b[WIDTH-1];
        a_mag    = in_neg_a ? -a : a;
        b_mag    = in_neg_b ? -b : b;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: abort always returns to IDLE and blocks a new start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && !abort) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the FIX cycle publishes the result unless it is aborted.
    always_comb begin
        accept      = (state_q == IDLE) && start && !abort;
        write_res   = (state_q == FIX) && !abort;
        done        = write_res;
        div_by_zero = write_res && op_q[1] && b_zero_q;
    end

    // Sign correction of the finished magnitudes into HI/LO values.
    always_comb begin
        prod_fix = {acc_q, mq_q};
        if (~op_q[0] && (neg_a_q ^ neg_b_q)) prod_fix = -prod_fix;
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (op_q[1]) begin
            // With a zero divisor every step succeeds, so the remainder ends
            // up holding |a|; re-signing it reproduces the raw dividend.
            res_hi = (~op_q[0] && neg_a_q) ? -acc_q : acc_q;
            res_lo = (~op_q[0] && (neg_a_q ^ neg_b_q)) ? -mq_q : mq_q;
            if (b_zero_q) res_lo = '1;
        end
    end

    // Working-register, counter and HI/LO next-state logic.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        m_d      = m_q;
        if (accept) begin
            cnt_d    = CW'(N);
            op_d     = op;
            neg_a_d  = in_neg_a;
            neg_b_d  = in_neg_b;
            b_zero_d = (b == '0);
            acc_d    = '0;
            mq_d     = a_mag;
            m_d      = b_mag;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - CW'(1);
            acc_d = run_hi;
            mq_d  = run_lo;
        end
        // Direct writes land in any state; a completing operation wins.
        hi_d = hi_we ? wdata : hi_q;
        lo_d = lo_we ? wdata : lo_q;
        if (write_res) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed bench for md_iter_unit: one instance with UNROLL=1 and one with
// UNROLL=4 share operands; results are predicted with native arithmetic.
module tb_md_iter_unit;

    localparam int W  = 32;
    localparam int EW = 2 * W + 1;   // {div_by_zero, hi, lo}

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start1 = 1'b0, start4 = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0, wdata = '0;
    logic         abort = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic         busy1, done1, dbz1, busy4, done4, dbz4;
    logic [W-1:0] hi1, lo1, hi4, lo4;

    logic [EW-1:0] exp1_q[$];
    logic [EW-1:0] exp4_q[$];
    logic [EW-1:0] pexp1, pexp4;
    logic          pend1 = 1'b0, pend4 = 1'b0;
    int            n_cmp = 0, n_bad = 0;
    int            c1, c4, d1, d4;

    always #5 clk = ~clk;

    md_iter_unit #(.WIDTH(W), .UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .b(b),
        .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy1), .done(done1), .div_by_zero(dbz1), .hi(hi1), .lo(lo1)
    );

    md_iter_unit #(.WIDTH(W), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .b(b),
        .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy4), .done(done4), .div_by_zero(dbz4), .hi(hi4), .lo(lo4)
    );

    function automatic logic [EW-1:0] model(input logic [1:0] o,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0]        up;
        logic signed [31:0] q, r;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: begin sp = sx * sy; return {1'b0, sp}; end
            2'b01: begin up = {32'b0, x} * {32'b0, y}; return {1'b0, up}; end
            2'b10: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {1'b0, 32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {1'b0, r, q};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start1 = 1'b1; start4 = 1'b1;
        exp1_q.push_back(model(o, x, y));
        exp4_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Follow both units to completion; optional injections at given busy cycles.
    task automatic watch(input int hiwe_at, input int lowe_at, input int start_at);
        int n;
        n = 0; c1 = 0; c4 = 0; d1 = 0; d4 = 0;
        do begin
            @(negedge clk);
            n++;
            hi_we = 1'b0; lo_we = 1'b0; start1 = 1'b0;
            if (pend1) begin
                check("hi_u1", hi1, pexp1[63:32]);
                check("lo_u1", lo1, pexp1[31:0]);
                pend1 = 1'b0;
            end
            if (pend4) begin
                check("hi_u4", hi4, pexp4[63:32]);
                check("lo_u4", lo4, pexp4[31:0]);
                pend4 = 1'b0;
            end
            if (done1) begin
                d1++;
                check("done_u1_expected", exp1_q.size() != 0, 1);
                if (exp1_q.size() != 0) begin
                    pexp1 = exp1_q.pop_front();
                    pend1 = 1'b1;
                    check("dbz_u1", dbz1, pexp1[64]);
                end
            end else check("dbz_u1_without_done", dbz1, 0);
            if (done4) begin
                d4++;
                check("done_u4_expected", exp4_q.size() != 0, 1);
                if (exp4_q.size() != 0) begin
                    pexp4 = exp4_q.pop_front();
                    pend4 = 1'b1;
                    check("dbz_u4", dbz4, pexp4[64]);
                end
            end
            if (busy1) c1++;
            if (busy4) c4++;
            if (busy1 && c1 == hiwe_at) begin hi_we = 1'b1; wdata = $urandom; end
            if (busy1 && c1 == lowe_at) begin lo_we = 1'b1; wdata = $urandom; end
            if (busy1 && c1 == start_at) begin
                start1 = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
            end
        end while ((busy1 || busy4 || pend1 || pend4) && n < 200);
        check("watch_bound", n < 200, 1);
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hiwe_at, input int lowe_at, input int start_at);
        launch(o, x, y);
        watch(hiwe_at, lowe_at, start_at);
        check("busy_cycles_u1", c1, 33);
        check("busy_cycles_u4", c4, 9);
        check("done_count_u1", d1, 1);
        check("done_count_u4", d4, 1);
        check("queue_drained", exp1_q.size() + exp4_q.size(), 0);
    endtask

    initial begin
        int seen;
        // Asynchronous reset values.
        #2;
        check("rst_hi", hi1, 0);
        check("rst_lo", lo1, 0);
        check("rst_busy", {busy1, busy4}, 0);
        check("rst_done", {done1, done4, dbz1, dbz4}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Test-plan operations and boundaries.
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        check("multu_hi", hi1, 32'hFFFF_FFFE);
        check("multu_lo", lo1, 32'h0000_0001);
        run(2'b00, 32'hFFFF_FFFD, 32'd5, 5, 0, 0);          // MTHI mid-run overwritten
        check("mult_lo_u4", lo4, 32'hFFFF_FFF1);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 33, 0);         // MTLO on the FIX edge loses
        check("div_lo", lo1, 32'hFFFF_FFFD);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 20); // start while busy ignored
        run(2'b11, 32'd100, 32'd0, 0, 0, 0);
        check("divu0_hi", hi1, 32'h0000_0064);
        run(2'b10, 32'hFFFF_FF9C, 32'd0, 0, 0, 0);
        run(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);
        run(2'b11, 32'hFFFF_FFFF, 32'd10, 0, 0, 0);
        run(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] rb;
            rb = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 300));
            run(2'($urandom_range(0, 3)), $urandom, rb, 0, 0, 0);
        end

        // abort together with start in IDLE: nothing launches.
        @(negedge clk);
        op = 2'b01; a = 32'd3; b = 32'd4; start1 = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_beats_start", busy1, 0);

        // Preload LO, start MULTU, stray start at cycle 5, abort at cycle 10.
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        @(negedge clk);
        check("lo_preload", lo1, 32'h1234_5678);
        op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_1234; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        c1 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1) c1++;
            if (i == 5) begin start1 = 1'b1; op = 2'b10; a = $urandom; b = $urandom; end
            if (i == 10) begin abort = 1'b1; start1 = 1'b1; end
        end
        check("busy_before_abort", c1, 10);
        @(posedge clk);
        #1;
        abort = 1'b0; start1 = 1'b0;
        @(negedge clk);
        check("busy_after_abort", busy1, 0);
        check("done_after_abort", done1, 0);
        check("lo_after_abort", lo1, 32'h1234_5678);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy1 || done1) seen++;
        end
        check("stays_idle", seen, 0);
        check("lo_still_preload", lo1, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md_iter_unit.md
Name: md_iter_unit

Overview:
- Parametrised iterative multiply/divide unit with integrated HI/LO registers. It replaces the fixed 32-bit multiply/divide block and separate HI/LO pair in the CPU datapath.
- Accepts MULT/MULTU/DIV/DIVU on a start/busy/done handshake. The busy output drives the CPU PC stall.
- Adds an abort (exception flush), direct HI/LO writes (MTHI/MTLO), a divide-by-zero flag, and selectable bits per cycle.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- UNROLL, 1, iteration steps per clock (1, 2 or 4); WIDTH must be divisible by UNROLL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- abort  in  1  cancel in-flight operation.
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight (CPU stall).
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_by_zero  out  1  one-cycle pulse with done for DIV/DIVU with b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; all internal working registers cleared.
- States:
  - IDLE: start=1 and abort=0 at a rising edge latch op, |a| and |b| (magnitudes for signed ops) and the operand signs, then go to RUN. The step counter loads N=WIDTH/UNROLL.
  - RUN: each clock performs UNROLL radix-2 steps (multiply: shift-add; divide: restoring shift-subtract) and decrements the counter. The edge on which the counter reaches 0 goes to FIX.
  - FIX: apply sign correction, write hi/lo, assert done (and div_by_zero if applicable) for that one cycle, return to IDLE.
- Latency: busy=1 for exactly N+1 cycles after the accepting edge (N RUN cycles + 1 FIX cycle). Results are visible on hi/lo in the cycle after FIX; done is high during FIX. With WIDTH=32, UNROLL=1: 33 busy cycles.
- busy is a registered output, 1 in RUN and FIX, 0 in IDLE.
- Multiply result: {hi,lo} = full 2*WIDTH product; signed for MULT, unsigned for MULTU.
- Divide result: lo = quotient truncated toward zero; hi = remainder, taking the sign of the dividend.
- Divide by zero (b==0): full normal latency; lo = all ones, hi = a (raw input value); div_by_zero pulses with done.
- Signed overflow, DIV of most-negative by -1: lo = most-negative value (0x80000000 for WIDTH=32), hi = 0; no flag.
- start while busy: ignored; no queueing.
- abort in RUN or FIX: next state IDLE, busy=0 next cycle, hi/lo unchanged, no done.
- abort and start together in IDLE: abort wins; start is ignored.
- hi_we/lo_we: write wdata at the edge in any state.
- Same-edge conflict: a FIX write of hi/lo beats hi_we/lo_we on the same edge.
- A hi_we/lo_we during RUN is overwritten at completion.
- Operand inputs a/b/op are don't-care after the accepting edge.

Decomposition:
- Shared package md_pkg:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - state enum (IDLE, RUN, FIX);
  - the counter-width function clog2(WIDTH/UNROLL+1).
- One sub-module, md_step: a combinational single radix-2 step (mode input selects add-shift or subtract-shift), chained UNROLL times inside md_iter_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done pulse once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; repeat with UNROLL=4 -> same result, busy 9 cycles.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 coincident with done.
- Preload via lo_we=1, wdata=0x12345678; start MULTU; assert abort on busy cycle 10; assert start during busy -> busy=0 next cycle, no done, lo=0x12345678; the busy-time start never launches an operation.
